// File: rtl/keypad_scan_debounce_pkg.sv
// Shared keypad geometry, the debounced output record, and helpers for
// row drive patterns and frame classification.
package keypad_scan_debounce_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = 16;
    localparam logic [KP_ROWS-1:0] ROW_IDLE = 4'b1111;

    typedef struct packed {
        logic [KP_KEYS-1:0] pad;
        logic               key_valid;
        logic [3:0]         key_code;
        logic               multi_key;
    } kp_state_t;

    function automatic logic [KP_ROWS-1:0] row_drive(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

    // Single key publishes its bit and index; two or more collapse to multi_key.
    function automatic kp_state_t classify(input logic [KP_KEYS-1:0] frame);
        kp_state_t  s;
        logic [4:0] hits;
        logic [3:0] idx;
        hits = '0;
        idx  = '0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (frame[i]) begin
                hits = hits + 5'd1;
                idx  = 4'(i);
            end
        end
        s = '0;
        if (hits == 5'd1) begin
            s.pad       = frame;
            s.key_valid = 1'b1;
            s.key_code  = idx;
        end else if (hits > 5'd1) begin
            s.multi_key = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: publishes a new key state only after DEBOUNCE_FRAMES
// identical frames, with one-cycle press/release strobes on each change.
module keypad_frame_debounce
    import keypad_scan_debounce_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_KEYS-1:0] raw,
    input  logic               frame_done,
    output logic [KP_KEYS-1:0] pad,
    output logic               key_valid,
    output logic [3:0]         key_code,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               multi_key
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

    logic [KP_KEYS-1:0] last_raw, nxt_last;
    logic [CW-1:0]      stable_cnt, nxt_cnt;
    kp_state_t          cur, new_state;
    logic               accept;

    // NOTE: defaults first so every path assigns every output; no latch.
    always_comb begin
        nxt_last = last_raw;
        nxt_cnt  = stable_cnt;
        if (frame_done) begin
            if (raw == last_raw) begin
                nxt_cnt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
            end else begin
                nxt_last = raw;
                nxt_cnt  = CW'(1);
            end
        end
    end

    assign new_state = classify(nxt_last);
    assign accept    = frame_done && (nxt_cnt == CNT_MAX) && (new_state != cur);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_raw      <= '0;
            stable_cnt    <= '0;
            cur           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            last_raw      <= nxt_last;
            stable_cnt    <= nxt_cnt;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (accept) begin
                cur           <= new_state;
                press_pulse   <= new_state.key_valid &&
                                 (!cur.key_valid || cur.key_code != new_state.key_code);
                release_pulse <= cur.key_valid &&
                                 (!new_state.key_valid || new_state.key_code != cur.key_code);
            end
        end
    end

    assign pad       = cur.pad;
    assign key_valid = cur.key_valid;
    assign key_code  = cur.key_code;
    assign multi_key = cur.multi_key;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: drives rows one at a time, synchronizes and samples
// the columns, assembles full frames and hands them to the frame debouncer.
module keypad_scan_debounce
    import keypad_scan_debounce_pkg::*;
#(
    parameter int ROW_DWELL_CYCLES = 50000,
    parameter int DEBOUNCE_FRAMES  = 5
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic [KP_COLS-1:0] cols_n,
    output logic [KP_ROWS-1:0] rows_n,
    output logic [KP_KEYS-1:0] pad,
    output logic               key_valid,
    output logic [3:0]         key_code,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               multi_key
);

    localparam int DW = $clog2(ROW_DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL_CYCLES - 1);

    logic [KP_COLS-1:0] cols_meta_n, cols_sync_n;
    logic               scan_active;
    logic [1:0]         row_idx;
    logic [DW-1:0]      dwell_cnt;
    logic [11:0]        frame_buf;
    logic               sample_now, frame_done;
    logic [KP_KEYS-1:0] raw;

    // Released columns read high through the pull-ups, so sync flops idle at 1.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cols_meta_n <= '1;
            cols_sync_n <= '1;
        end else begin
            cols_meta_n <= cols_n;
            cols_sync_n <= cols_meta_n;
        end
    end

    assign sample_now = scan_active && (dwell_cnt == DWELL_LAST);
    assign frame_done = sample_now && (row_idx == 2'd3);
    assign raw        = {~cols_sync_n, frame_buf};
    assign rows_n     = scan_active ? row_drive(row_idx) : ROW_IDLE;

    // NOTE: frame_buf is reset so the first completed frame is well defined.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            scan_active <= 1'b0;
            row_idx     <= '0;
            dwell_cnt   <= '0;
            frame_buf   <= '0;
        end else begin
            scan_active <= 1'b1;
            if (scan_active) begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    row_idx   <= row_idx + 2'd1;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end
            if (sample_now) begin
                case (row_idx)
                    2'd0:    frame_buf[3:0]  <= ~cols_sync_n;
                    2'd1:    frame_buf[7:4]  <= ~cols_sync_n;
                    2'd2:    frame_buf[11:8] <= ~cols_sync_n;
                    default: ;
                endcase
            end
        end
    end

    keypad_frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk          (CLOCK_50),
        .rst_n        (reset_n),
        .raw          (raw),
        .frame_done   (frame_done),
        .pad          (pad),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .multi_key    (multi_key)
    );

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a short dwell (4) and
// debounce window (3 frames); a behavioural keypad drives cols_n from rows_n.
module tb_keypad_scan_debounce;

    logic        clk;
    logic        reset_n;
    logic [3:0]  cols_n;
    logic [3:0]  rows_n;
    logic [15:0] pad;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        press_pulse;
    logic        release_pulse;
    logic        multi_key;

    logic [15:0] held;
    int          cyc;
    int          total;
    int          bad;

    keypad_scan_debounce #(
        .ROW_DWELL_CYCLES(4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .CLOCK_50     (clk),
        .reset_n      (reset_n),
        .cols_n       (cols_n),
        .rows_n       (rows_n),
        .pad          (pad),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .multi_key    (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A held key shorts its row to its column.
    always_comb begin
        cols_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows_n[r] && held[r*4+c]) cols_n[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the middle of scan cycle 'target'.
    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] e_pad, input logic e_valid,
                              input logic [3:0] e_code, input logic e_multi,
                              input logic e_press, input logic e_release);
        check({tag, ".pad"},     32'(pad),           32'(e_pad));
        check({tag, ".valid"},   32'(key_valid),     32'(e_valid));
        check({tag, ".code"},    32'(key_code),      32'(e_code));
        check({tag, ".multi"},   32'(multi_key),     32'(e_multi));
        check({tag, ".press"},   32'(press_pulse),   32'(e_press));
        check({tag, ".release"}, 32'(release_pulse), 32'(e_release));
    endtask

    initial begin
        int          presses;
        logic        pad_seen;
        logic [3:0]  exp_rows;

        total   = 0;
        bad     = 0;
        cyc     = 0;
        reset_n = 1'b0;
        held    = 16'h0040;

        repeat (3) @(negedge clk);
        check("reset.rows", 32'(rows_n), 32'h0000000F);
        check_outs("reset", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        reset_n = 1'b1;
        cyc     = -1;

        for (int c = 0; c <= 16; c++) begin
            goto(c);
            exp_rows = 4'b1111 ^ (4'b0001 << ((c / 4) % 4));
            check("scan.rows", 32'(rows_n), 32'(exp_rows));
        end

        goto(47);
        check_outs("press6.before", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        goto(48);
        check_outs("press6", 16'h0040, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        goto(49);
        check("press6.pulse_end", 32'(press_pulse), 32'h0);
        goto(64);
        check_outs("press6.sat", 16'h0040, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);

        held = 16'h0000;
        goto(111);
        check_outs("release6.before", 16'h0040, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        goto(112);
        check_outs("release6", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        goto(113);
        check("release6.pulse_end", 32'(release_pulse), 32'h0);

        goto(128);
        held     = 16'h0200;
        presses  = 0;
        pad_seen = 1'b0;
        for (int c = 129; c <= 239; c++) begin
            goto(c);
            if (press_pulse) presses++;
            if (pad != 16'h0) pad_seen = 1'b1;
            if (c == 144 || c == 176) held = 16'h0000;
            if (c == 160 || c == 192) held = 16'h0200;
        end
        check("bounce.early_press", 32'(presses), 32'h0);
        check("bounce.early_pad", 32'(pad_seen), 32'h0);
        goto(240);
        check_outs("bounce9", 16'h0200, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
        presses = 0;
        for (int c = 241; c <= 271; c++) begin
            goto(c);
            if (press_pulse) presses++;
        end
        check("bounce9.no_repeat", 32'(presses), 32'h0);

        held = 16'h0021;
        goto(319);
        check_outs("multi.before", 16'h0200, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        goto(320);
        check_outs("multi", 16'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        goto(321);
        check("multi.pulse_end", 32'(release_pulse), 32'h0);

        goto(336);
        held = 16'h0008;
        goto(384);
        check_outs("key3", 16'h0008, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);

        goto(400);
        held = 16'h1000;
        goto(447);
        check_outs("key12.before", 16'h0008, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        goto(448);
        check_outs("key3to12", 16'h1000, 1'b1, 4'd12, 1'b0, 1'b1, 1'b1);

        goto(450);
        #2 reset_n = 1'b0;
        #1;
        check("async.rows", 32'(rows_n), 32'h0000000F);
        check_outs("async", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cyc     = -1;
        goto(0);
        check("rerun.rows", 32'(rows_n), 32'h0000000E);
        check_outs("rerun.start", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        goto(47);
        check_outs("rerun.before", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        goto(48);
        check_outs("rerun", 16'h1000, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
